// File: rtl/stream_cipher_pkg.sv
// Shared types and constants for the stream-cipher sequencing controller.
package stream_cipher_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WARMUP,
    ST_FILL,
    ST_READY
  } ctrl_state_t;

  localparam int KS_BYTE_BITS = 8;

  // Defaults shared with the keystream generator.
  localparam int DEF_KEY_W  = 16;
  localparam int DEF_WARMUP = 32;

endpackage

// File: rtl/stream_cipher_ks_shift.sv
// Keystream byte collector: gathers generator bits LSB first and flags the
// cycle in which the last bit of a byte is being taken.
module stream_cipher_ks_shift
  import stream_cipher_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    shift_en,
  input  logic                    bit_in,
  output logic [KS_BYTE_BITS-1:0] byte_out,
  output logic                    full
);

  localparam int CNT_W = $clog2(KS_BYTE_BITS);

  logic [KS_BYTE_BITS-1:0] byte_q, byte_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  // Shifting in at the MSB leaves the first sample in bit 0 after a full byte.
  always_comb begin
    byte_d = byte_q;
    cnt_d  = cnt_q;
    if (clr) begin
      byte_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      byte_d = {bit_in, byte_q[KS_BYTE_BITS-1:1]};
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_q <= '0;
      cnt_q  <= '0;
    end else begin
      byte_q <= byte_d;
      cnt_q  <= cnt_d;
    end
  end

  assign byte_out = byte_q;
  assign full     = shift_en && !clr && (cnt_q == CNT_W'(KS_BYTE_BITS - 1));

endmodule

// File: rtl/stream_cipher_ctrl.sv
// Seeds the keystream generator, discards warm-up bits, collects keystream
// bytes and XORs them with the plaintext stream.
//
//   state      | meaning
//   ST_IDLE    | waiting for start
//   ST_LOAD    | one-cycle seed load into the generator
//   ST_WARMUP  | stepping the generator, bits discarded
//   ST_FILL    | stepping the generator, collecting 8 keystream bits
//   ST_READY   | keystream byte ready, waiting for a plaintext byte
module stream_cipher_ctrl
  import stream_cipher_pkg::*;
#(
  parameter int KEY_W  = DEF_KEY_W,
  parameter int WARMUP = DEF_WARMUP
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [KEY_W-1:0]        key,
  output logic                    gen_load,
  output logic [KEY_W-1:0]        gen_seed,
  output logic                    gen_step,
  input  logic                    gen_bit,
  input  logic                    in_valid,
  input  logic [KS_BYTE_BITS-1:0] in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [KS_BYTE_BITS-1:0] out_data,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int WCNT_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

  ctrl_state_t             state_q, state_d;
  logic [KEY_W-1:0]        seed_q, seed_d;
  logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
  logic                    gen_load_q, gen_load_d;
  logic                    gen_step_q, gen_step_d;
  logic                    out_valid_q, out_valid_d;
  logic [KS_BYTE_BITS-1:0] out_data_q, out_data_d;

  logic                    ks_clr;
  logic                    ks_shift;
  logic                    ks_full;
  logic [KS_BYTE_BITS-1:0] ks_byte;
  logic                    abort;
  logic                    accept;

  assign abort    = stop && (state_q != ST_IDLE);
  assign in_ready = (state_q == ST_READY) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready && !stop;
  assign ks_shift = (state_q == ST_FILL);
  assign ks_clr   = abort;

  stream_cipher_ks_shift u_ks_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (ks_clr),
    .shift_en (ks_shift),
    .bit_in   (gen_bit),
    .byte_out (ks_byte),
    .full     (ks_full)
  );

  always_comb begin
    state_d     = state_q;
    seed_d      = seed_q;
    wcnt_d      = wcnt_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_LOAD;
          seed_d  = key;
        end
      end
      ST_LOAD: begin
        if (WARMUP == 0) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_WARMUP;
          wcnt_d  = WCNT_W'(WARMUP);
        end
      end
      ST_WARMUP: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (wcnt_q == WCNT_W'(1)) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (ks_full) state_d = ST_READY;
      end
      ST_READY: begin
        // Refill starts immediately; the byte just produced waits in the output register.
        if (accept) begin
          out_data_d  = in_data ^ ks_byte;
          out_valid_d = 1'b1;
          state_d     = ST_FILL;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      wcnt_d      = '0;
    end

    // Generator strobes are registered, so they are decoded from the next state.
    gen_load_d = (state_d == ST_LOAD);
    gen_step_d = (state_d == ST_WARMUP) || (state_d == ST_FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      seed_q      <= '0;
      wcnt_q      <= '0;
      gen_load_q  <= 1'b0;
      gen_step_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      wcnt_q      <= wcnt_d;
      gen_load_q  <= gen_load_d;
      gen_step_q  <= gen_step_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign gen_load  = gen_load_q;
  assign gen_seed  = seed_q;
  assign gen_step  = gen_step_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_stream_cipher_ctrl.sv
// Bench for stream_cipher_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a timeline model.
module tb_stream_cipher_ctrl;

  localparam int KW = 16;
  localparam int W  = 4;

  logic clk = 1'b0;
  logic rst, start, stop, in_valid, out_ready;
  logic [KW-1:0] key;
  logic [7:0] in_data;
  logic gen_load, gen_step, gen_bit, in_ready, out_valid, busy;
  logic [KW-1:0] gen_seed;
  logic [7:0] out_data;
  logic z_load, z_step, z_in_ready, z_out_valid, z_busy;
  logic [KW-1:0] z_seed;
  logic [7:0] z_out_data;

  always #5 clk = ~clk;

  stream_cipher_ctrl #(.KEY_W(KW), .WARMUP(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .key(key),
    .gen_load(gen_load), .gen_seed(gen_seed), .gen_step(gen_step), .gen_bit(gen_bit),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .busy(busy)
  );

  stream_cipher_ctrl #(.KEY_W(KW), .WARMUP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .key(key),
    .gen_load(z_load), .gen_seed(z_seed), .gen_step(z_step), .gen_bit(1'b1),
    .in_valid(in_valid), .in_data(in_data), .in_ready(z_in_ready),
    .out_valid(z_out_valid), .out_data(z_out_data), .out_ready(out_ready), .busy(z_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Generator model: 0 = constant 1, 1 = alternating 1,0,.. from load, 2 = LFSR.
  int gmode = 0;
  logic [15:0] g_st = 16'h0;
  logic [31:0] g_cnt = 0;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  always @(posedge clk) begin
    if (gen_load) begin
      g_st  <= gen_seed;
      g_cnt <= 0;
    end else if (gen_step) begin
      g_st  <= lfsr_next(g_st);
      g_cnt <= g_cnt + 1;
    end
  end

  assign gen_bit = (gmode == 0) ? 1'b1 : (gmode == 1) ? ~g_cnt[0] : g_st[0];

  // Keystream byte n = generator bits after W+8n .. W+8n+7 steps from the seed.
  function automatic logic [7:0] ref_ks(input int mode, input logic [15:0] seed, input int n);
    logic [15:0] s;
    logic [7:0] b;
    int first;
    s = seed;
    b = 8'h00;
    first = W + 8 * n;
    for (int i = 0; i < first + 8; i++) begin
      if (i >= first) b[i-first] = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 2 == 0) : s[0];
      s = lfsr_next(s);
    end
    return b;
  endfunction

  // Timeline model: absolute cycle numbers of load, step window and readiness.
  bit m_active = 1'b0;
  bit m_ov = 1'b0;
  bit m_ir;
  logic [15:0] m_seed = 16'h0;
  logic [7:0] m_od = 8'h0;
  int m_load_cyc = 0, m_step_first = 0, m_ready_cyc = 0, m_nbyte = 0;

  initial forever begin
    @(posedge clk);
    m_ir = m_active && cyc >= m_ready_cyc && (!m_ov || out_ready);
    if (rst) begin
      m_active = 1'b0;
      m_seed   = 16'h0;
      m_ov     = 1'b0;
      m_od     = 8'h0;
    end else if (!m_active) begin
      if (start && !stop) begin
        m_active     = 1'b1;
        m_seed       = key;
        m_load_cyc   = cyc + 1;
        m_step_first = cyc + 2;
        m_ready_cyc  = cyc + 10 + W;
        m_nbyte      = 0;
      end
    end else if (stop) begin
      m_active = 1'b0;
      m_ov     = 1'b0;
    end else begin
      if (m_ov && out_ready) m_ov = 1'b0;
      if (in_valid && m_ir) begin
        m_od         = in_data ^ ref_ks(gmode, m_seed, m_nbyte);
        m_ov         = 1'b1;
        m_nbyte      = m_nbyte + 1;
        m_step_first = cyc + 1;
        m_ready_cyc  = cyc + 9;
      end
    end
    cyc = cyc + 1;
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("busy", busy, m_active);
      chk("gen_load", gen_load, m_active && cyc == m_load_cyc);
      chk("gen_seed", gen_seed, m_seed);
      chk("gen_step", gen_step, m_active && cyc >= m_step_first && cyc < m_ready_cyc);
      chk("in_ready", in_ready, m_active && cyc >= m_ready_cyc && (!m_ov || out_ready));
      chk("out_valid", out_valid, m_ov);
      if (m_ov) chk("out_data", out_data, m_od);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a session in the current cycle k and checks the load/warm-up/fill timeline.
  task automatic session_check(input logic [15:0] k_val, input bit with_w0);
    int nstep, zstep;
    start = 1'b1; key = k_val; out_ready = 1'b1;
    tick(); start = 1'b0; #3;
    chk("lit_load", gen_load, 1);
    chk("lit_seed", gen_seed, k_val);
    chk("lit_busy", busy, 1);
    if (with_w0) chk("lit_w0_load", z_load, 1);
    nstep = 0; zstep = 0;
    for (int i = 0; i < 12; i++) begin
      tick(); #3;
      if (gen_step) nstep++;
      if (z_step) zstep++;
      chk("lit_in_ready_low", in_ready, 0);
      if (with_w0 && i == 7) chk("lit_w0_ready_k9", z_in_ready, 0);
      if (with_w0 && i == 8) chk("lit_w0_ready_k10", z_in_ready, 1);
    end
    chk("lit_step_count", nstep, 12);
    if (with_w0) chk("lit_w0_step_count", zstep, 8);
    tick(); #3;
    chk("lit_in_ready_k14", in_ready, 1);
    chk("lit_step_k14", gen_step, 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; key = '0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    tick();
    chk_en = 1'b1;
    tick(); tick();
    rst = 1'b0; #3;
    chk("rst_outputs", {gen_load, gen_step, in_ready, out_valid, busy}, 0);
    chk("rst_seed", gen_seed, 0);
    chk("rst_data", out_data, 0);
    chk("rst_w0_outputs", {z_load, z_step, z_in_ready, z_out_valid, z_busy}, 0);

    // Constant-1 keystream, both warm-up settings.
    session_check(16'hBEEF, 1'b1);
    in_valid = 1'b1; in_data = 8'h5A;
    tick(); in_valid = 1'b0; #3;
    chk("lit_const_valid", out_valid, 1);
    chk("lit_const_data", out_data, 8'hA5);
    chk("lit_w0_data", z_out_data, 8'hA5);

    // Alternating keystream 0x55 per byte.
    stop = 1'b1;
    tick(); stop = 1'b0; gmode = 1; #3;
    chk("lit_stop_busy", busy, 0);
    chk("lit_stop_valid", out_valid, 0);
    session_check(16'h1234, 1'b0);
    in_valid = 1'b1; in_data = 8'h0F;
    tick(); in_valid = 1'b0; #3;
    chk("lit_alt_data0", out_data, 8'h5A);
    n = 0;
    while (!in_ready && n < 30) begin
      tick(); #3;
      n++;
    end
    chk("lit_ready_gap", n, 8);
    in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b0;
    tick(); in_valid = 1'b0; #3;
    chk("lit_alt_data1", out_data, 8'hAA);

    // Backpressure: refill completes but nothing is accepted while output is held.
    repeat (8) tick();
    #3;
    chk("lit_bp_step", gen_step, 0);
    chk("lit_bp_ready", in_ready, 0);
    chk("lit_bp_valid", out_valid, 1);
    tick(); #3;
    chk("lit_bp_ready2", in_ready, 0);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h33; #1;
    chk("lit_bp_release", in_ready, 1);
    tick(); in_valid = 1'b0; out_ready = 1'b0; #3;
    chk("lit_replace_valid", out_valid, 1);
    chk("lit_replace_data", out_data, 8'h66);

    // Abort on the fourth fill step with a byte pending, then a full restart.
    tick(); tick(); tick();
    stop = 1'b1;
    tick(); stop = 1'b0; #3;
    chk("lit_abort_busy", busy, 0);
    chk("lit_abort_valid", out_valid, 0);
    chk("lit_abort_step", gen_step, 0);
    session_check(16'hCAFE, 1'b0);

    // start while READY is ignored.
    start = 1'b1; key = 16'h0000;
    tick(); start = 1'b0; #3;
    chk("lit_ready_start_load", gen_load, 0);
    chk("lit_ready_start_seed", gen_seed, 16'hCAFE);
    chk("lit_ready_start_ready", in_ready, 1);

    // start and stop together in IDLE.
    stop = 1'b1;
    tick(); start = 1'b1; stop = 1'b1;
    tick(); start = 1'b0; stop = 1'b0; #3;
    chk("lit_startstop_busy", busy, 0);
    chk("lit_startstop_load", gen_load, 0);

    // Reset during warm-up.
    start = 1'b1; key = 16'h7777;
    tick(); start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick(); rst = 1'b0; #3;
    chk("lit_rst_outputs", {gen_load, gen_step, in_ready, out_valid, busy}, 0);
    chk("lit_rst_seed", gen_seed, 0);
    chk("lit_rst_data", out_data, 0);

    // Randomized traffic with an LFSR generator.
    gmode = 2;
    for (int i = 0; i < 5000; i++) begin
      tick();
      start     = ($urandom_range(0, 3) == 0);
      key       = 16'($urandom);
      stop      = ($urandom_range(0, 199) == 0);
      rst       = ($urandom_range(0, 799) == 0);
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    tick();
    rst = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
